// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory bus controller: state encoding and default widths.
package mips_pkg;

  localparam int unsigned DMEM_ADDR_W      = 32;
  localparam int unsigned DMEM_DATA_W      = 32;
  localparam int unsigned DMEM_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_REQ  = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_watchdog.sv
// REQ-phase watchdog: counts REQ cycles without ack and flags expiry on the TIMEOUT_CYC-th one.
module dmem_watchdog
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DMEM_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  input  logic ack,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (active && !ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the cycle whose miss would make the count reach TIMEOUT_CYC; an ack there wins.
  assign expire = active && !ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Core load/store to req/ack bus bridge with core stall. Optional REQ timeout under DMEM_TIMEOUT_EN.
module dmem_bus_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W      = DMEM_ADDR_W,
  parameter int unsigned DATA_W      = DMEM_DATA_W,
  parameter int unsigned TIMEOUT_CYC = DMEM_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("dmem_bus_ctrl: TIMEOUT_CYC must be at least 1");
  end

  dmem_state_e       state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_err_q, bus_err_d;
  logic              mem_op;
  logic              timeout;

  assign mem_op = mem_read || mem_write;

`ifdef DMEM_TIMEOUT_EN
  dmem_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (reset),
    .start (state_q == DMEM_IDLE && mem_op),
    .active(state_q == DMEM_REQ),
    .ack   (bus_ack),
    .expire(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_err_d   = bus_err_q;
    stall       = 1'b0;
    unique case (state_q)
      DMEM_IDLE: begin
        if (mem_op) begin
          stall       = 1'b1;
          state_d     = DMEM_REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = addr & ~ADDR_W'(3);
          bus_wdata_d = wdata;
        end
      end
      DMEM_REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          state_d   = DMEM_DONE;
          bus_req_d = 1'b0;
          if (!bus_we_q) rdata_d = bus_rdata;
        end else if (timeout) begin
          state_d   = DMEM_DONE;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!bus_we_q) rdata_d = '0;
        end
      end
      DMEM_DONE: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= DMEM_IDLE;
      rdata_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Bench for dmem_bus_ctrl: directed and random instructions against a transaction-level model.
module tb_dmem_bus_ctrl;

`ifdef DMEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int unsigned TC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_rdata;
  logic        m_err;

  always #5 clk = ~clk;

  dmem_bus_ctrl #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT_CYC(TC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack),
    .bus_err  (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One core instruction; the bench plays both the core and an ack-after-dly slave.
  task automatic do_instr(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input int unsigned dly, input logic [31:0] rv);
    bit          is_mem = rd || wr;
    bit          done = 1'b0;
    bit          timed_out;
    int unsigned exp_req;
    int unsigned stall_cnt = 0;
    int unsigned req_cnt = 0;
    timed_out = TO_EN && is_mem && (dly + 1 > TC);
    exp_req   = !is_mem ? 0 : (timed_out ? TC : dly + 1);
    @(posedge clk); #1;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    bus_ack   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stall_cnt++;
      if (bus_req) begin
        req_cnt++;
        check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
        check("bus_we", {31'd0, bus_we}, {31'd0, wr});
        if (wr) check("bus_wdata", bus_wdata, wd);
        bus_ack   = (req_cnt == dly + 1);
        bus_rdata = bus_ack ? rv : $urandom();
      end else begin
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom();
      end
    end
    check("completed", {31'd0, done}, 32'd1);
    if (is_mem && !wr) m_rdata = timed_out ? 32'd0 : rv;
    if (timed_out) m_err = 1'b1;
    check("stall_cycles", stall_cnt, is_mem ? exp_req + 1 : 0);
    check("req_cycles", req_cnt, exp_req);
    check("rdata", rdata, m_rdata);
    check("bus_req_gap", {31'd0, bus_req}, 32'd0);
    check("bus_err", {31'd0, bus_err}, {31'd0, m_err});
  endtask

  task automatic check_reset_outputs();
    check("rst_rdata", rdata, 32'd0);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int unsigned op;
    int unsigned long_dly;
    m_rdata = '0;
    m_err   = 1'b0;

    // Reset sequence
    #12;
    check_reset_outputs();
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    check("post_rst_bus_req", {31'd0, bus_req}, 32'd0);

    // Aligned-down load, ack in first REQ cycle
    do_instr(1'b1, 1'b0, 32'h0000_1007, 32'h0, 0, 32'hCAFE_F00D);
    // Store with wait cycles; rdata must keep the load value
    long_dly = TO_EN ? 3 : 5;
    do_instr(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, long_dly, 32'hDEAD_BEEF);
    // Load immediately followed by store
    do_instr(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1, 32'h0BAD_CAFE);
    do_instr(1'b0, 1'b1, 32'h0000_0203, 32'hA5A5_5A5A, 0, 32'h1111_1111);
    // Both strobes: treated as a write
    do_instr(1'b1, 1'b1, 32'h0000_0302, 32'h7777_8888, 2, 32'h2222_2222);
    // Non-memory instruction adds no stall
    do_instr(1'b0, 1'b0, 32'h0000_0400, 32'h0, 0, 32'h3333_3333);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      do_instr(op[0], op[1], $urandom(), $urandom(), $urandom_range(0, 3), $urandom());
    end

    // Reset asserted mid-REQ
    @(posedge clk); #1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    addr      = 32'h0000_0500;
    bus_ack   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_req_bus_req", {31'd0, bus_req}, 32'd1);
    #2;
    reset     = 1'b0;
    mem_read  = 1'b0;
    #1;
    check("async_drop_bus_req", {31'd0, bus_req}, 32'd0);
    m_rdata = '0;
    m_err   = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_0000;
    @(negedge clk);
    bus_ack = 1'b0;
    check("post_abort_stall", {31'd0, stall}, 32'd0);
    check("post_abort_rdata", rdata, 32'd0);
    check("post_abort_bus_req", {31'd0, bus_req}, 32'd0);
    do_instr(1'b1, 1'b0, 32'h0000_0600, 32'h0, 1, 32'h4444_5555);

    if (TO_EN) begin
      // Ack on the last allowed cycle wins over the timeout
      do_instr(1'b1, 1'b0, 32'h0000_0700, 32'h0, TC - 1, 32'h6666_7777);
      // No ack: timeout, rdata cleared, sticky error
      do_instr(1'b1, 1'b0, 32'h0000_0800, 32'h0, 1000, 32'h9999_9999);
      do_instr(1'b0, 1'b1, 32'h0000_0900, 32'h1357_9BDF, 1000, 32'h0);
      do_instr(1'b1, 1'b0, 32'h0000_0A00, 32'h0, 0, 32'h2468_ACE0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      m_rdata = '0;
      m_err   = 1'b0;
      check_reset_outputs();
      @(negedge clk);
      reset = 1'b1;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
